// File: rtl/xadc_pkg.sv
// Shared XADC DRP constants, widths and sampler FSM states.
// Used by the pair sampler and its accumulators.
package xadc_pkg;

    localparam int DRP_DATA_W = 16;
    localparam int DRP_ADDR_W = 7;
    localparam int ADC_W      = 12;

    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUXP2 = 7'h12;
    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUXP3 = 7'h13;

    typedef enum logic [2:0] {
        IDLE,
        REQ_L,
        WAIT_L,
        REQ_R,
        WAIT_R,
        UPDATE
    } state_t;

    // DRP status registers carry the 12-bit result left-justified
    function automatic logic [ADC_W-1:0] drp_result(
        input logic [DRP_DATA_W-1:0] d
    );
        return d[DRP_DATA_W-1 -: ADC_W];
    endfunction

endpackage

// File: rtl/sample_accumulator.sv
// Sums 2^AVG_LOG2 12-bit samples; avg is the sum scaled back to 12 bits.
// Width is exact, so the sum never wraps.
module sample_accumulator
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] avg
);

    localparam int AW = ADC_W + AVG_LOG2;

    logic [AW-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + AW'(din);
        end
    end

    assign avg = acc[AW-1:AVG_LOG2];

endmodule

// File: rtl/xadc_pair_sampler.sv
// Reads VAUXP3/VAUXP2 over DRP on each EOC, averages read pairs and
// publishes registered samples; flags DRP timeouts stickily.
module xadc_pair_sampler
    import xadc_pkg::*;
#(
    parameter logic [6:0] ADDR_L         = 7'h13,
    parameter logic [6:0] ADDR_R         = 7'h12,
    parameter int         AVG_LOG2       = 2,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  eoc_in,
    input  logic                  drdy_in,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  den_out,
    output logic                  dwe_out,
    output logic [DRP_ADDR_W-1:0] daddr_out,
    output logic [DRP_DATA_W-1:0] vauxp3,
    output logic [DRP_DATA_W-1:0] vauxp2,
    output logic                  sample_valid,
    output logic                  timeout_err
);

    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] PAIR_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   pair_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            add_l;
    logic            add_r;
    logic            acc_clr;
    logic            publish;
    logic            tmo_hit;
    logic            waiting;
    logic [ADC_W-1:0] sample;
    logic [ADC_W-1:0] avg_l;
    logic [ADC_W-1:0] avg_r;
    logic            unused_nib;

    assign sample     = drp_result(do_in);
    assign unused_nib = ^do_in[3:0];
    assign waiting    = (state == WAIT_L) || (state == WAIT_R);
    assign dwe_out    = 1'b0;

    always_comb begin
        nxt     = state;
        add_l   = 1'b0;
        add_r   = 1'b0;
        acc_clr = 1'b0;
        publish = 1'b0;
        tmo_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (eoc_in) nxt = REQ_L;
            end
            REQ_L: nxt = WAIT_L;
            WAIT_L: begin
                if (drdy_in) begin
                    add_l = 1'b1;
                    nxt   = REQ_R;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    acc_clr = 1'b1;
                    nxt     = IDLE;
                end
            end
            REQ_R: nxt = WAIT_R;
            WAIT_R: begin
                if (drdy_in) begin
                    add_r = 1'b1;
                    nxt   = UPDATE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    acc_clr = 1'b1;
                    nxt     = IDLE;
                end
            end
            UPDATE: begin
                nxt = IDLE;
                if (pair_cnt == PAIR_LAST) begin
                    publish = 1'b1;
                    acc_clr = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            den_out   <= 1'b0;
            daddr_out <= '0;
            tmo_cnt   <= '0;
            pair_cnt  <= '0;
        end else begin
            state   <= nxt;
            den_out <= (nxt == REQ_L) || (nxt == REQ_R);
            if (nxt == REQ_L) begin
                daddr_out <= ADDR_L;
            end else if (nxt == REQ_R) begin
                daddr_out <= ADDR_R;
            end
            // restarts from zero on every entry into a wait state
            tmo_cnt <= waiting ? tmo_cnt + 1'b1 : '0;
            if (tmo_hit || publish) begin
                pair_cnt <= '0;
            end else if (state == UPDATE) begin
                pair_cnt <= pair_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            vauxp3       <= '0;
            vauxp2       <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            sample_valid <= publish;
            timeout_err  <= timeout_err | tmo_hit;
            if (publish) begin
                vauxp3 <= DRP_DATA_W'(avg_l);
                vauxp2 <= DRP_DATA_W'(avg_r);
            end
        end
    end

    sample_accumulator #(
        .AVG_LOG2(AVG_LOG2)
    ) u_acc_l (
        .clk(CLK100MHZ),
        .rst(rst),
        .clr(acc_clr),
        .add(add_l),
        .din(sample),
        .avg(avg_l)
    );

    sample_accumulator #(
        .AVG_LOG2(AVG_LOG2)
    ) u_acc_r (
        .clk(CLK100MHZ),
        .rst(rst),
        .clr(acc_clr),
        .add(add_r),
        .din(sample),
        .avg(avg_r)
    );

endmodule

// File: tb/tb_xadc_pair_sampler.sv
// Bench: two samplers (no averaging / 4-pair averaging) on a shared DRP
// stimulus, checked against a pair-level reference model.
module tb_xadc_pair_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] dat = 16'h0;

    logic        den0, dwe0, sv0, te0;
    logic [6:0]  addr0;
    logic [15:0] v3_0, v2_0;
    logic        den2, dwe2, sv2, te2;
    logic [6:0]  addr2;
    logic [15:0] v3_2, v2_2;

    int checks = 0;
    int errors = 0;
    int den_cnt0 = 0, den_cnt2 = 0, sv_cnt0 = 0, sv_cnt2 = 0;

    // reference model state
    int e3_0 = 0, e2_0 = 0, e3_2 = 0, e2_2 = 0;
    int sum_l = 0, sum_r = 0, npair = 0;
    int exp_den = 0, exp_sv0 = 0, exp_sv2 = 0;
    int exp_te = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        den_cnt0 <= den_cnt0 + (den0 ? 1 : 0);
        den_cnt2 <= den_cnt2 + (den2 ? 1 : 0);
        sv_cnt0  <= sv_cnt0 + (sv0 ? 1 : 0);
        sv_cnt2  <= sv_cnt2 + (sv2 ? 1 : 0);
    end

    xadc_pair_sampler #(
        .ADDR_L(7'h13), .ADDR_R(7'h12),
        .AVG_LOG2(0), .TIMEOUT_CYCLES(8)
    ) dut0 (
        .CLK100MHZ(clk), .rst(rst), .eoc_in(eoc), .drdy_in(drdy),
        .do_in(dat), .den_out(den0), .dwe_out(dwe0), .daddr_out(addr0),
        .vauxp3(v3_0), .vauxp2(v2_0), .sample_valid(sv0),
        .timeout_err(te0)
    );

    xadc_pair_sampler #(
        .ADDR_L(7'h13), .ADDR_R(7'h12),
        .AVG_LOG2(2), .TIMEOUT_CYCLES(8)
    ) dut2 (
        .CLK100MHZ(clk), .rst(rst), .eoc_in(eoc), .drdy_in(drdy),
        .do_in(dat), .den_out(den2), .dwe_out(dwe2), .daddr_out(addr2),
        .vauxp3(v3_2), .vauxp2(v2_2), .sample_valid(sv2),
        .timeout_err(te2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".v3_0"}, v3_0, e3_0);
        chk({tag, ".v2_0"}, v2_0, e2_0);
        chk({tag, ".v3_2"}, v3_2, e3_2);
        chk({tag, ".v2_2"}, v2_2, e2_2);
        chk({tag, ".te0"}, te0, exp_te);
        chk({tag, ".te2"}, te2, exp_te);
        chk({tag, ".dwe"}, {dwe0, dwe2}, 0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ".den0"}, den_cnt0, exp_den);
        chk({tag, ".den2"}, den_cnt2, exp_den);
        chk({tag, ".sv0"}, sv_cnt0, exp_sv0);
        chk({tag, ".sv2"}, sv_cnt2, exp_sv2);
    endtask

    task automatic start_read(input string tag);
        @(negedge clk) eoc = 1'b1;
        @(negedge clk) eoc = 1'b0;
        chk({tag, ".den_l"}, {den0, den2}, 2'b11);
        chk({tag, ".addr_l"}, {addr0, addr2}, {7'h13, 7'h13});
    endtask

    // one full pair; wl/wr = idle wait cycles before drdy (0..7)
    task automatic pair(input int l, input int r, input int wl,
                        input int wr, input bit noise);
        logic [15:0] dl, dr;
        bit pub2;
        dl = {l[11:0], 4'($urandom)};
        dr = {r[11:0], 4'($urandom)};
        start_read("pair");
        @(negedge clk);
        for (int i = 0; i < wl; i++) begin
            eoc = noise && (i == 0);
            @(negedge clk);
        end
        eoc = 1'b0;
        drdy = 1'b1;
        dat = dl;
        @(negedge clk);
        drdy = 1'b0;
        dat = 16'($urandom);
        chk("pair.den_r", {den0, den2}, 2'b11);
        chk("pair.addr_r", {addr0, addr2}, {7'h12, 7'h12});
        @(negedge clk);
        for (int i = 0; i < wr; i++) @(negedge clk);
        drdy = 1'b1;
        dat = dr;
        @(negedge clk);
        drdy = 1'b0;
        eoc = noise;
        chk("pair.sv_update", {sv0, sv2}, 2'b00);
        @(negedge clk);
        eoc = 1'b0;
        exp_den += 2;
        e3_0 = l;
        e2_0 = r;
        exp_sv0++;
        sum_l += l;
        sum_r += r;
        npair++;
        pub2 = (npair == 4);
        if (pub2) begin
            e3_2 = sum_l / 4;
            e2_2 = sum_r / 4;
            exp_sv2++;
            sum_l = 0;
            sum_r = 0;
            npair = 0;
        end
        chk("pair.sv_pub", {sv0, sv2}, {1'b1, pub2});
        check_outs("pair");
        @(negedge clk);
        chk("pair.sv_drop", {sv0, sv2}, 2'b00);
        check_counts("pair");
    endtask

    // right read never answered
    task automatic timeout_run(input int l);
        start_read("tmo");
        @(negedge clk);
        drdy = 1'b1;
        dat = {l[11:0], 4'h0};
        @(negedge clk);
        drdy = 1'b0;
        repeat (8) @(negedge clk);
        chk("tmo.before", {te0, te2}, {exp_te[0], exp_te[0]});
        @(negedge clk);
        exp_te = 1;
        exp_den += 2;
        sum_l = 0;
        sum_r = 0;
        npair = 0;
        check_outs("tmo");
        repeat (2) @(negedge clk);
        check_counts("tmo");
    endtask

    initial begin
        #3 rst = 1'b1;
        #1;
        chk("rst.den", {den0, den2}, 0);
        chk("rst.addr", {addr0, addr2}, 0);
        chk("rst.sv", {sv0, sv2}, 0);
        check_outs("rst");
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        check_counts("idle");

        // reset during WAIT_R, then a stale drdy
        start_read("mid");
        @(negedge clk);
        drdy = 1'b1;
        dat = 16'hABC0;
        @(negedge clk);
        drdy = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_den += 2;
        chk("mid.den", {den0, den2}, 0);
        chk("mid.addr", {addr0, addr2}, 0);
        @(negedge clk) rst = 1'b0;
        drdy = 1'b1;
        dat = 16'h5550;
        @(negedge clk) drdy = 1'b0;
        repeat (3) @(negedge clk);
        check_outs("mid");
        check_counts("mid");

        pair(12'h7D0, 12'h3E8, 3, 3, 1'b0);
        chk("dir.v3", v3_0, 2000);
        chk("dir.v2", v2_0, 1000);

        timeout_run(12'h123);

        pair(12'h100, 12'h010, 0, 0, 1'b0);
        pair(12'h200, 12'h020, 7, 7, 1'b0);
        pair(12'h300, 12'h030, 1, 2, 1'b1);
        pair(12'h400, 12'h040, 2, 0, 1'b1);
        chk("avg4.v3", v3_2, 16'h280);
        chk("avg4.v2", v2_2, 16'h028);

        // drdy while idle is ignored
        drdy = 1'b1;
        dat = 16'hFFF0;
        @(negedge clk) drdy = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("idle_drdy");
        check_counts("idle_drdy");

        for (int k = 0; k < 6; k++) begin
            pair($urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom));
        end
        timeout_run($urandom_range(0, 4095));
        for (int k = 0; k < 4; k++) begin
            pair($urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom));
        end
        pair(4095, 4095, 0, 0, 1'b0);
        pair(4095, 4095, 7, 0, 1'b0);
        pair(4095, 4095, 0, 7, 1'b0);
        pair(4095, 4095, 1, 1, 1'b0);

        repeat (3) @(negedge clk);
        check_outs("final");
        check_counts("final");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
